// File: rtl/depermuter_4x4_stream_if.sv
// Handshake bundle for the 4-lane depermuter: control-code stream, permuted input beats, restored output.
// The slave modport is the depermuter side; the master modport is the producer/consumer side.
interface depermuter_4x4_stream_if #(
  parameter int SIZE      = 4,
  parameter int CTL_DEPTH = 4
);
  localparam int LW = $clog2(CTL_DEPTH) + 1;

  logic                  flush;
  logic                  ctl_valid;
  logic                  ctl_ready;
  logic [1:0]            ctl_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0][SIZE-1:0]  in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0][SIZE-1:0]  out_data;
  logic [1:0]            out_ctl;
  logic [LW-1:0]         ctl_level;

  modport slave (
    input  flush, ctl_valid, ctl_data, in_valid, in_data, out_ready,
    output ctl_ready, in_ready, out_valid, out_data, out_ctl, ctl_level
  );

  modport master (
    output flush, ctl_valid, ctl_data, in_valid, in_data, out_ready,
    input  ctl_ready, in_ready, out_valid, out_data, out_ctl, ctl_level
  );
endinterface

// File: rtl/depermuter_4x4_stream.sv
// Restores lane order of permuted 4-lane beats using codes queued in a small FIFO; one output register,
// latency 1, full throughput; input stalls on empty FIFO or held output (out_valid & !out_ready).
module depermuter_4x4_stream #(
  parameter int SIZE      = 4,
  parameter int CTL_DEPTH = 4
) (
  input logic                    clk,
  input logic                    rst,
  depermuter_4x4_stream_if.slave bus
);
  localparam int AW = $clog2(CTL_DEPTH);
  localparam int LW = AW + 1;

  logic [1:0]           mem_q [CTL_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 out_valid_q, out_valid_d;
  logic [3:0][SIZE-1:0] out_data_q, out_data_d;
  logic [1:0]           out_ctl_q, out_ctl_d;

  logic                 push, pop, can_load;
  logic [1:0]           head;
  logic [3:0][SIZE-1:0] restored;

  // ctl_ready looks only at the registered level, so a same-cycle pop never frees a slot early.
  assign bus.ctl_ready = (level_q < LW'(CTL_DEPTH));
  assign can_load      = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = (level_q != '0) && can_load && !bus.flush;

  assign push = bus.ctl_valid && bus.ctl_ready && !bus.flush;
  assign pop  = bus.in_valid && bus.in_ready;
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    restored = '0;
    for (int i = 0; i < 4; i++) begin
      restored[i] = bus.in_data[2'(i) ^ head];
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ctl_d   = out_ctl_q;
    if (bus.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (pop) begin
        out_valid_d = 1'b1;
        out_data_d  = restored;
        out_ctl_d   = head;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ctl_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ctl_q   <= out_ctl_d;
    end
  end

  // Storage needs no reset: the level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.ctl_data;
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ctl   = out_ctl_q;
  assign bus.ctl_level = level_q;
endmodule

// File: tb/tb_depermuter_4x4_stream.sv
// Bench for depermuter_4x4_stream: directed scenarios then random traffic, checked against a queue-based model
// that tracks original (un-permuted) beats and the code queue.
module tb_depermuter_4x4_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  depermuter_4x4_stream_if #(.SIZE(4), .CTL_DEPTH(4)) bus ();
  depermuter_4x4_stream #(.SIZE(4), .CTL_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // reference model state
  logic [1:0]  mq[$];
  logic        ov_m = 1'b0;
  logic [15:0] od_m = '0;
  logic [1:0]  oc_m = '0;
  logic        known = 1'b1;
  logic [15:0] cur_orig = '0;
  logic        taken, pushed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Forward permutation applied by the link's transmitter: lane i takes lane i^c.
  function automatic logic [15:0] perm(input logic [15:0] w, input logic [1:0] c);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = w[(i ^ int'(c))*4 +: 4];
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    ov_m = 1'b0; od_m = '0; oc_m = '0; known = 1'b1;
  endtask

  task automatic cycle();
    logic cr, ir;
    @(negedge clk);
    bus.in_data = perm(cur_orig, (mq.size() != 0) ? mq[0] : 2'b00);
    cr = (mq.size() < 4);
    ir = (mq.size() != 0) && (!ov_m || bus.out_ready) && !bus.flush;
    chk("ctl_ready", {31'd0, bus.ctl_ready}, {31'd0, cr});
    chk("in_ready",  {31'd0, bus.in_ready},  {31'd0, ir});
    chk("ctl_level", {29'd0, bus.ctl_level}, mq.size());
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, ov_m});
    if (known) begin
      chk("out_data", {16'd0, bus.out_data}, {16'd0, od_m});
      chk("out_ctl",  {30'd0, bus.out_ctl},  {30'd0, oc_m});
    end
    taken  = bus.in_valid && ir;
    pushed = bus.ctl_valid && cr && !bus.flush;
    if (bus.flush) begin
      mq.delete();
      ov_m  = 1'b0;
      known = 1'b0;
    end else begin
      if (taken) begin
        oc_m = mq.pop_front();
        od_m = cur_orig;
        ov_m = 1'b1;
        known = 1'b1;
      end else if (ov_m && bus.out_ready) begin
        ov_m = 1'b0;
      end
      if (pushed) mq.push_back(bus.ctl_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_code(input logic [1:0] c);
    bus.ctl_valid = 1'b1;
    bus.ctl_data  = c;
    pushed = 1'b0;
    for (int k = 0; k < 50 && !pushed; k++) cycle();
    chk("push_done", {31'd0, pushed}, 32'd1);
    bus.ctl_valid = 1'b0;
  endtask

  initial begin
    bus.flush = 1'b0; bus.ctl_valid = 1'b0; bus.ctl_data = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    taken = 1'b0; pushed = 1'b0;

    // reset state
    @(posedge clk); #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_level",     {29'd0, bus.ctl_level}, 32'd0);
    chk("rst_ctl_ready", {31'd0, bus.ctl_ready}, 32'd1);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    chk("rst_out_data",  {16'd0, bus.out_data},  32'd0);
    chk("rst_out_ctl",   {30'd0, bus.out_ctl},   32'd0);
    rst = 1'b0;
    model_reset();
    cycle();

    // all four codes, back-to-back beats restoring {D,C,B,A}
    for (int k = 0; k < 4; k++) push_code(2'(k));
    bus.in_valid = 1'b1;
    cur_orig = 16'hDCBA;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t2_b2b", {31'd0, taken}, 32'd1);
    end
    bus.in_valid = 1'b0;
    cycle();
    chk("t2_last_ctl", {30'd0, bus.out_ctl}, 32'd3);
    chk("t2_last_dat", {16'd0, bus.out_data}, 32'hDCBA);
    cycle();

    // empty FIFO blocks data; a pushed code is usable only on the next cycle
    bus.in_valid = 1'b1;
    cur_orig = 16'($urandom);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t3_empty_stall", {31'd0, taken}, 32'd0);
    end
    bus.ctl_valid = 1'b1; bus.ctl_data = 2'b01;
    cycle();
    chk("t3_push_n", {31'd0, pushed}, 32'd1);
    chk("t3_nobypass", {31'd0, taken}, 32'd0);
    bus.ctl_valid = 1'b0;
    cycle();
    chk("t3_take_n1", {31'd0, taken}, 32'd1);
    bus.in_valid = 1'b0;
    cycle();
    cycle();

    // full FIFO, held-off push, pop with concurrent push, wrap order
    for (int k = 0; k < 4; k++) push_code(2'($urandom));
    bus.ctl_valid = 1'b1; bus.ctl_data = 2'($urandom);
    cycle();
    chk("t4_full_hold", {31'd0, pushed}, 32'd0);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (taken) cur_orig = 16'($urandom);
      bus.ctl_data = 2'($urandom);
      cycle();
    end
    bus.ctl_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (taken) cur_orig = 16'($urandom);
      cycle();
    end
    bus.in_valid = 1'b0;
    cycle();

    // backpressure: hold output for 3 cycles, then stream
    for (int k = 0; k < 3; k++) push_code(2'($urandom));
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    cur_orig = 16'($urandom);
    cycle();
    bus.out_ready = 1'b0;
    cur_orig = 16'($urandom);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t5_stall", {31'd0, taken}, 32'd0);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("t5_resume", {31'd0, taken}, 32'd1);
      cur_orig = 16'($urandom);
    end
    bus.in_valid = 1'b0;
    cycle();
    cycle();

    // flush with level 3 and a pending output, while pushing 10
    for (int k = 0; k < 4; k++) push_code(2'($urandom));
    bus.in_valid = 1'b1;
    cur_orig = 16'($urandom);
    cycle();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush = 1'b1; bus.ctl_valid = 1'b1; bus.ctl_data = 2'b10; bus.in_valid = 1'b1;
    cycle();
    bus.flush = 1'b0; bus.ctl_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("t6_level", {29'd0, bus.ctl_level}, 32'd0);
    chk("t6_out_valid", {31'd0, bus.out_valid}, 32'd0);
    cur_orig = 16'($urandom);
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("t6_stall", {31'd0, taken}, 32'd0);
    end
    bus.ctl_valid = 1'b1; bus.ctl_data = 2'b11;
    cycle();
    bus.ctl_valid = 1'b0;
    cycle();
    chk("t6_resume", {31'd0, taken}, 32'd1);
    bus.in_valid = 1'b0;
    cycle();

    // asynchronous reset mid-stream with level 2 and a pending output
    for (int k = 0; k < 3; k++) push_code(2'($urandom));
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    cur_orig = 16'($urandom);
    cycle();
    bus.in_valid = 1'b0;
    chk("t1_pre_level", {29'd0, bus.ctl_level}, 32'd2);
    chk("t1_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t1_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t1_level",     {29'd0, bus.ctl_level}, 32'd0);
    chk("t1_ctl_ready", {31'd0, bus.ctl_ready}, 32'd1);
    #1;
    rst = 1'b0;
    model_reset();
    bus.out_ready = 1'b1;
    cycle();

    // random traffic
    cur_orig = 16'($urandom);
    for (int k = 0; k < 400; k++) begin
      if (taken) cur_orig = 16'($urandom);
      bus.flush     = ($urandom_range(0, 39) == 0);
      bus.ctl_valid = 1'($urandom_range(0, 1));
      bus.ctl_data  = 2'($urandom);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.flush = 1'b0; bus.ctl_valid = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
